// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU definitions: opcode encoding (alu_op_t), the
//                multi-cycle controller state encoding (alu_state_t) and a
//                small opcode classification helper. Imported by the
//                multi-cycle ALU, its decoder and the single-cycle alu.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    // Opcode encoding. Gaps in the 4-bit space are illegal opcodes.
    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_LSL   = 4'b0011,
        OP_LSR   = 4'b0100,
        OP_SUB   = 4'b0110,
        OP_PASSB = 4'b0111,
        OP_MUL   = 4'b1000,
        OP_UDIV  = 4'b1001,
        OP_NOR   = 4'b1100
    } alu_op_t;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    // Opcodes serviced by the iterative multiply/divide datapath.
    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_UDIV);
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv
//  Description : Iterative unsigned multiply (low N bits, shift-add) and
//                unsigned divide (restoring), one bit per clock, N clocks.
//                Both operations share one N-bit accumulator, one N-bit
//                shift register and a log2(N)+1-bit iteration counter.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                start           - load operands, begin N iterations
//                is_div          - 1: a/b, 0: a*b (sampled with start)
//                a, b            - operands (sampled with start)
//                done            - high during the final iteration cycle
//                q               - result valid while done is high
//  Revision    : 1.0  initial release
// ============================================================================
module alu_muldiv #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         is_div,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         done,
    output logic [N-1:0] q
);

    localparam int c_cnt_w = $clog2(N) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(N);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(1);

    logic [N-1:0]       r_acc;      // product (mul) / partial remainder (div)
    logic [N-1:0]       r_sr;       // multiplier (mul) / dividend->quotient (div)
    logic [N-1:0]       r_opb;      // multiplicand / divisor
    logic               r_is_div;
    logic [c_cnt_w-1:0] r_cnt;

    logic [N-1:0]       w_acc_next;
    logic [N-1:0]       w_sr_next;
    logic [N:0]         w_trial;
    logic               w_fits;

    always_comb begin
        w_acc_next = r_acc;
        w_sr_next  = r_sr;
        // Remainder shifted left with the next dividend bit, minus divisor.
        // Bit N of the difference is set exactly when the divisor does not fit.
        w_trial    = {r_acc, r_sr[N-1]} - {1'b0, r_opb};
        w_fits     = ~w_trial[N];
        if (r_is_div) begin
            w_acc_next = w_fits ? w_trial[N-1:0] : {r_acc[N-2:0], r_sr[N-1]};
            w_sr_next  = {r_sr[N-2:0], w_fits};
        end else begin
            // MSB-first shift-add: acc = 2*acc + bit*b, truncated to N bits.
            w_acc_next = {r_acc[N-2:0], 1'b0} + (r_sr[N-1] ? r_opb : '0);
            w_sr_next  = {r_sr[N-2:0], 1'b0};
        end
    end

    // The result is taken from the next-state value so the owner can capture
    // it on the same edge as the last iteration.
    assign done = (r_cnt == c_cnt_last);
    assign q    = r_is_div ? w_sr_next : w_acc_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_sr     <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_cnt    <= '0;
        end else if (start) begin
            r_acc    <= '0;
            r_sr     <= a;
            r_opb    <= b;
            r_is_div <= is_div;
            r_cnt    <= c_cnt_init;
        end else if (r_cnt != '0) begin
            r_acc    <= w_acc_next;
            r_sr     <= w_sr_next;
            r_cnt    <= r_cnt - c_cnt_last;
        end
    end

endmodule : alu_muldiv
`default_nettype wire

// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
//  Module      : alu_multicycle
//  Description : N-bit ALU with valid/ready handshakes. Logic, add/sub,
//                pass and shifts complete in one cycle; MUL and UDIV run on
//                the iterative alu_muldiv datapath for N cycles. Result,
//                flags and err are registered and held until consumed.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                in_valid / in_ready - request handshake (ready only in IDLE)
//                a, b, op            - operands and opcode, latched on accept
//                out_valid/out_ready - result handshake
//                result              - registered result
//                zero, negative, carry, overflow - registered flags
//                err                 - illegal opcode or divide-by-zero
//  Revision    : 1.0  initial release
// ============================================================================
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         negative,
    output logic         carry,
    output logic         overflow,
    output logic         err
);

    localparam int c_sh_w = $clog2(N);

    alu_state_t   r_state;
    alu_state_t   w_state_next;

    logic         w_accept;
    logic         w_is_mc;
    logic         w_md_start;
    logic         w_md_is_div;
    logic         w_md_done;
    logic [N-1:0] w_md_q;
    logic [N-1:0] w_mc_res;

    logic [N:0]        w_add;
    logic [N:0]        w_sub;
    logic [c_sh_w-1:0] w_shamt;
    logic [N-1:0]      w_sc_res;
    logic              w_sc_carry;
    logic              w_sc_ovf;
    logic              w_sc_err;

    logic [N-1:0] r_result;
    logic         r_zero;
    logic         r_neg;
    logic         r_carry;
    logic         r_ovf;
    logic         r_err;
    logic         r_div_zero;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign in_ready    = (r_state == ST_IDLE) && !reset;
    assign w_accept    = in_valid && in_ready;
    assign w_is_mc     = is_multicycle(op);
    assign w_md_start  = w_accept && w_is_mc;
    assign w_md_is_div = (op == OP_UDIV);

    // ------------------------------------------------------------------
    // Single-cycle operations
    // ------------------------------------------------------------------
    always_comb begin
        // a + ~b + 1: bit N is the carry-out, i.e. "no borrow" (a >= b).
        w_add      = {1'b0, a} + {1'b0, b};
        w_sub      = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
        w_shamt    = b[c_sh_w-1:0];
        w_sc_res   = '0;
        w_sc_carry = 1'b0;
        w_sc_ovf   = 1'b0;
        w_sc_err   = 1'b0;
        case (alu_op_t'(op))
            OP_AND:   w_sc_res = a & b;
            OP_OR:    w_sc_res = a | b;
            OP_NOR:   w_sc_res = ~(a | b);
            OP_PASSB: w_sc_res = b;
            OP_LSL:   w_sc_res = a << w_shamt;
            OP_LSR:   w_sc_res = a >> w_shamt;
            OP_ADD: begin
                w_sc_res   = w_add[N-1:0];
                w_sc_carry = w_add[N];
                w_sc_ovf   = (a[N-1] == b[N-1]) && (w_add[N-1] != a[N-1]);
            end
            OP_SUB: begin
                w_sc_res   = w_sub[N-1:0];
                w_sc_carry = w_sub[N];
                w_sc_ovf   = (a[N-1] != b[N-1]) && (w_sub[N-1] != a[N-1]);
            end
            OP_MUL, OP_UDIV: w_sc_res = '0;
            default:  w_sc_err = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Iterative multiply / divide
    // ------------------------------------------------------------------
    alu_muldiv #(
        .N      (N)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (w_md_start),
        .is_div (w_md_is_div),
        .a      (a),
        .b      (b),
        .done   (w_md_done),
        .q      (w_md_q)
    );

    // Divide-by-zero still runs the full iteration; its result is forced to 0.
    assign w_mc_res = r_div_zero ? '0 : w_md_q;

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_is_mc ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                if (w_md_done) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Result and flag registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_neg      <= 1'b0;
            r_carry    <= 1'b0;
            r_ovf      <= 1'b0;
            r_err      <= 1'b0;
            r_div_zero <= 1'b0;
        end else if (w_accept) begin
            r_div_zero <= (op == OP_UDIV) && (b == '0);
            if (!w_is_mc) begin
                r_result <= w_sc_res;
                // An illegal opcode reports err only; zero stays low.
                r_zero   <= !w_sc_err && (w_sc_res == '0);
                r_neg    <= w_sc_res[N-1];
                r_carry  <= w_sc_carry;
                r_ovf    <= w_sc_ovf;
                r_err    <= w_sc_err;
            end
        end else if ((r_state == ST_BUSY) && w_md_done) begin
            r_result <= w_mc_res;
            r_zero   <= (w_mc_res == '0);
            r_neg    <= w_mc_res[N-1];
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= r_div_zero;
        end
    end

    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign negative  = r_neg;
    assign carry     = r_carry;
    assign overflow  = r_ovf;
    assign err       = r_err;

endmodule : alu_multicycle
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_multicycle
//  Description : Self-checking bench for alu_multicycle. Two instances
//                (N=64 and N=8) share stimulus; sel picks the active one.
//                Directed vector table, directed hold/reset sequences and
//                random operations checked against an arithmetic model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_multicycle;

    typedef struct {
        logic [63:0] res;
        logic        z, n, c, v, e;
        int          lat;
    } exp_t;

    typedef struct {
        logic        s;
        logic [3:0]  op;
        logic [63:0] a, b;
        int          hold;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;          // 0: 64-bit DUT, 1: 8-bit DUT
    logic        iv = 1'b0;
    logic        ordy = 1'b0;
    logic [63:0] a = '0, b = '0;
    logic [3:0]  op = '0;

    logic        ir64, ov64, z64, n64, c64, v64, e64;
    logic [63:0] res64;
    logic        ir8, ov8, z8, n8, c8, v8, e8;
    logic [7:0]  res8;

    logic        iv64, iv8, or64, or8;
    logic        obs_ir, obs_ov, obs_z, obs_n, obs_c, obs_v, obs_e;
    logic [63:0] obs_res;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign iv64 = iv & ~sel;
    assign iv8  = iv & sel;
    assign or64 = ordy & ~sel;
    assign or8  = ordy & sel;

    assign obs_ir  = sel ? ir8 : ir64;
    assign obs_ov  = sel ? ov8 : ov64;
    assign obs_z   = sel ? z8  : z64;
    assign obs_n   = sel ? n8  : n64;
    assign obs_c   = sel ? c8  : c64;
    assign obs_v   = sel ? v8  : v64;
    assign obs_e   = sel ? e8  : e64;
    assign obs_res = sel ? {56'd0, res8} : res64;

    alu_multicycle #(.N(64)) dut64 (
        .clk(clk), .reset(reset), .in_valid(iv64), .in_ready(ir64),
        .a(a), .b(b), .op(op), .out_valid(ov64), .out_ready(or64),
        .result(res64), .zero(z64), .negative(n64), .carry(c64),
        .overflow(v64), .err(e64)
    );

    alu_multicycle #(.N(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
        .a(a[7:0]), .b(b[7:0]), .op(op), .out_valid(ov8), .out_ready(or8),
        .result(res8), .zero(z8), .negative(n8), .carry(c8),
        .overflow(v8), .err(e8)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: plain wide arithmetic on w-bit values.
    function automatic exp_t model(input int w, input logic [3:0] o,
                                   input logic [63:0] va, input logic [63:0] vb);
        exp_t e;
        logic [127:0]        mask, x, y, full, r;
        logic signed [127:0] sx, sy, ss, lim;
        int                  amt;
        mask = (128'd1 << w) - 128'd1;
        x    = {64'd0, va} & mask;
        y    = {64'd0, vb} & mask;
        sx   = x[w-1] ? (x | ~mask) : x;
        sy   = y[w-1] ? (y | ~mask) : y;
        lim  = 128'sd1 <<< (w - 1);
        e    = '{res: '0, z: 1'b0, n: 1'b0, c: 1'b0, v: 1'b0, e: 1'b0, lat: 1};
        r    = '0;
        amt  = int'(y % w);
        case (o)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b1100: r = ~(x | y) & mask;
            4'b0111: r = y;
            4'b0011: r = (x << amt) & mask;
            4'b0100: r = x >> amt;
            4'b0010: begin
                full = x + y;
                r    = full & mask;
                e.c  = full[w];
                ss   = sx + sy;
                e.v  = (ss >= lim) || (ss < -lim);
            end
            4'b0110: begin
                r    = (x - y) & mask;
                e.c  = (x >= y);
                ss   = sx - sy;
                e.v  = (ss >= lim) || (ss < -lim);
            end
            4'b1000: begin
                r     = (x * y) & mask;
                e.lat = w + 1;
            end
            4'b1001: begin
                e.lat = w + 1;
                if (y == 0) begin
                    r   = '0;
                    e.e = 1'b1;
                end else begin
                    r = x / y;
                end
            end
            default: begin
                e.e = 1'b1;
                return e;
            end
        endcase
        e.res = r[63:0];
        e.z   = (r == 0);
        e.n   = r[w-1];
        return e;
    endfunction

    function automatic vec_t mk(input logic s, input logic [3:0] o,
                                input logic [63:0] va, input logic [63:0] vb,
                                input int hold, input logic [63:0] res,
                                input logic z, input logic n, input logic c,
                                input logic v, input logic e, input int lat);
        vec_t t;
        t.s = s; t.op = o; t.a = va; t.b = vb; t.hold = hold;
        t.e.res = res; t.e.z = z; t.e.n = n; t.e.c = c; t.e.v = v;
        t.e.e = e; t.e.lat = lat;
        return t;
    endfunction

    // Issue one operation, measure latency, check outputs, hold, consume.
    task automatic run_op(input string tag, input logic s, input logic [3:0] o,
                          input logic [63:0] va, input logic [63:0] vb,
                          input int hold, input exp_t e);
        int lat;
        bit got;
        sel = s;
        @(negedge clk);
        for (int i = 0; i < 200 && !obs_ir; i++) @(negedge clk);
        chk({tag, ".in_ready_idle"}, {63'd0, obs_ir}, 64'd1);
        op = o; a = va; b = vb; iv = 1'b1;
        @(posedge clk);
        #1;
        iv = 1'b0;
        // Operands must be latched: scramble them while the op is in flight.
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = 4'($urandom);
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (obs_ov) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, ".out_valid"}, {63'd0, got}, 64'd1);
        chk({tag, ".latency"}, 64'(lat), 64'(e.lat));
        chk({tag, ".result"}, obs_res, e.res);
        chk({tag, ".flags_zncve"}, {59'd0, obs_z, obs_n, obs_c, obs_v, obs_e},
            {59'd0, e.z, e.n, e.c, e.v, e.e});
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, ".hold_result"}, obs_res, e.res);
            chk({tag, ".hold_valid_ready"}, {62'd0, obs_ov, obs_ir}, 64'd2);
        end
        ordy = 1'b1;
        @(posedge clk);
        #1;
        ordy = 1'b0;
        chk({tag, ".after_consume"}, {62'd0, obs_ov, obs_ir}, 64'd1);
    endtask

    localparam logic [3:0] c_ops[11] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
        4'b0111, 4'b1100, 4'b0011, 4'b0100, 4'b1000, 4'b1001, 4'b1111};

    vec_t tbl[16];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = mk(0, 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0,
                     64'h8000_0000_0000_0000, 0, 1, 0, 1, 0, 1);
        tbl[1]  = mk(0, 4'b0110, 64'd5, 64'd5, 3, 64'd0, 1, 0, 1, 0, 0, 1);
        tbl[2]  = mk(0, 4'b0011, 64'd1, 64'h43, 0, 64'd8, 0, 0, 0, 0, 0, 1);
        tbl[3]  = mk(0, 4'b0100, 64'h8000_0000_0000_0000, 64'd63, 0,
                     64'd1, 0, 0, 0, 0, 0, 1);
        tbl[4]  = mk(1, 4'b1000, 64'd13, 64'd11, 0, 64'h8F, 0, 1, 0, 0, 0, 9);
        tbl[5]  = mk(1, 4'b1001, 64'd200, 64'd7, 0, 64'd28, 0, 0, 0, 0, 0, 9);
        tbl[6]  = mk(1, 4'b1001, 64'd42, 64'd0, 0, 64'd0, 1, 0, 0, 0, 1, 9);
        tbl[7]  = mk(1, 4'b1111, 64'd42, 64'd3, 0, 64'd0, 0, 0, 0, 0, 1, 1);
        tbl[8]  = mk(0, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0,
                     64'd0, 1, 0, 1, 0, 0, 1);
        tbl[9]  = mk(0, 4'b0110, 64'd0, 64'd1, 0,
                     64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 0, 0, 1);
        tbl[10] = mk(0, 4'b1100, 64'd0, 64'd0, 0,
                     64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 0, 0, 1);
        tbl[11] = mk(0, 4'b0111, 64'd1, 64'h1234, 0, 64'h1234, 0, 0, 0, 0, 0, 1);
        tbl[12] = mk(1, 4'b0110, 64'h80, 64'd1, 0, 64'h7F, 0, 0, 1, 1, 0, 1);
        tbl[13] = mk(0, 4'b1000, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0,
                     64'hFFFF_FFFE_0000_0001, 0, 1, 0, 0, 0, 65);
        tbl[14] = mk(0, 4'b1001, 64'd100, 64'd10, 0, 64'd10, 0, 0, 0, 0, 0, 65);
        tbl[15] = mk(1, 4'b0001, 64'hF0, 64'h3C, 0, 64'hFC, 0, 1, 0, 0, 0, 1);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.in_ready_low", {62'd0, ir64, ir8}, 64'd0);
        chk("reset.out_valid", {62'd0, ov64, ov8}, 64'd0);
        chk("reset.result64", res64, 64'd0);
        chk("reset.flags64", {59'd0, z64, n64, c64, v64, e64}, 64'd0);
        chk("reset.flags8", {51'd0, res8, z8, n8, c8, v8, e8}, 64'd0);
        reset = 1'b0;
        #1;
        chk("release.in_ready", {62'd0, ir64, ir8}, 64'd3);

        // Directed vectors
        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].s, tbl[i].op, tbl[i].a,
                   tbl[i].b, tbl[i].hold, tbl[i].e);
        end

        // Reset in the middle of a multiply
        run_op("pre_rst", 0, 4'b0111, 64'd0, 64'hABCD, 0,
               model(64, 4'b0111, 64'd0, 64'hABCD));
        sel = 1'b0;
        @(negedge clk);
        op = 4'b1000; a = 64'd12345; b = 64'd678; iv = 1'b1;
        @(posedge clk);
        #1;
        iv = 1'b0;
        repeat (5) @(negedge clk);
        chk("midbusy.in_ready", {63'd0, ir64}, 64'd0);
        reset = 1'b1;
        #1;
        chk("rst_cycle.in_ready", {63'd0, ir64}, 64'd0);
        @(posedge clk);
        #1;
        chk("rst_abort.out_valid", {63'd0, ov64}, 64'd0);
        chk("rst_abort.result", res64, 64'd0);
        chk("rst_abort.flags", {59'd0, z64, n64, c64, v64, e64}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_release.in_ready", {63'd0, ir64}, 64'd1);
        run_op("post_rst_add", 0, 4'b0010, 64'd2, 64'd3, 0,
               model(64, 4'b0010, 64'd2, 64'd3));

        // Random operations against the model
        for (int i = 0; i < 40; i++) begin
            logic        s;
            logic [3:0]  o;
            logic [63:0] va, vb;
            int          h;
            s  = 1'($urandom);
            o  = c_ops[$urandom_range(0, 10)];
            va = {$urandom, $urandom};
            vb = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) vb = vb & 64'hFF;
            if ($urandom_range(0, 9) == 0) vb = 64'd0;
            h  = $urandom_range(0, 2);
            run_op($sformatf("rnd%0d", i), s, o, va, vb, h,
                   model(s ? 8 : 64, o, va, vb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_alu_multicycle
`default_nettype wire

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter N, default 64, meaning operand/result width; legal N is a power of two, 8..64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports in_valid input 1, in_ready output 1: operation-request handshake.
REQ-005 SHALL have ports a input N, b input N, op input 4: operands and opcode, sampled on accept.
REQ-006 SHALL have ports out_valid output 1, out_ready input 1: result handshake.
REQ-007 SHALL have port result output N: registered result.
REQ-008 SHALL have ports zero, negative, carry, overflow output 1 each: registered flags.
REQ-009 SHALL have port err output 1: illegal opcode or divide-by-zero for the held result.

Function
REQ-010 SHALL decode op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (a-b), 0111 PASS b, 1100 NOR, 0011 LSL (a << b[log2N-1:0]), 0100 LSR (logical), 1000 MUL (low N bits, unsigned), 1001 UDIV (unsigned quotient a/b).
REQ-011 SHALL treat any other op as illegal: result 0, err 1, all other flags 0, latency 1.
REQ-012 SHALL run FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-013 SHALL assert in_ready only in IDLE; accept occurs when in_valid && in_ready.
REQ-014 SHALL, on accept of single-cycle op (logic, ADD, SUB, PASS, shifts, illegal), go IDLE->DONE; result and out_valid visible the cycle after accept (latency 1).
REQ-015 SHALL, on accept of MUL/UDIV, go IDLE->BUSY, iterate one bit per cycle for exactly N cycles, then BUSY->DONE; out_valid first high N+1 cycles after accept.
REQ-016 SHALL implement MUL as shift-add and UDIV as restoring division, sharing one N-bit accumulator, one N-bit shift register and a log2(N)+1-bit counter.
REQ-017 SHALL hold result, flags, err and out_valid stable in DONE until out_ready; DONE->IDLE on out_valid && out_ready.
REQ-018 SHALL NOT accept a new request in the same cycle a result is consumed (in_ready low in DONE); back-to-back throughput is one op per 2 cycles minimum.
REQ-019 SHALL compute zero = (result == 0) and negative = result[N-1] for every legal op.
REQ-020 SHALL compute carry = carry-out of a+b for ADD, NOT borrow (a >= b unsigned) for SUB, 0 otherwise.
REQ-021 SHALL compute overflow = signed overflow for ADD and SUB, 0 otherwise.
REQ-022 SHALL, for UDIV with b == 0, produce result 0, err 1, zero 1, completing in the normal N+1 latency.
REQ-023 SHALL ignore a, b, op changes while BUSY or DONE (operands latched at accept).

Reset
REQ-024 SHALL, while reset is high at a rising edge, force state IDLE, out_valid 0, result 0, all flags 0, err 0, counter 0, regardless of state (including mid-BUSY; in-flight op discarded).
REQ-025 SHALL drive in_ready 0 during the reset cycle and 1 the first cycle after reset deasserts.

Structure
REQ-026 SHALL place opcode enum (alu_op_t) and FSM state enum in shared package alu_pkg, reused by the decoder and existing alu.
REQ-027 SHALL implement the iterative multiply/divide datapath as sub-module alu_muldiv (start, is_div, a, b -> done, q); single-cycle ops stay in the top module.

Verification
REQ-028 SHALL verify: N=64, ADD a=0x7FFF_FFFF_FFFF_FFFF b=1 -> result 0x8000_0000_0000_0000, negative 1, overflow 1, carry 0, out_valid 1 cycle after accept.
REQ-029 SHALL verify: N=64, SUB a=5 b=5 -> result 0, zero 1, carry 1; out_ready held low 3 cycles -> result stable, in_ready 0 throughout.
REQ-030 SHALL verify: N=8, MUL a=13 b=11 -> result 143 (0x8F), out_valid exactly 9 cycles after accept; UDIV a=200 b=7 -> 28.
REQ-031 SHALL verify: N=8, UDIV a=42 b=0 -> result 0, err 1, zero 1, latency 9; op=1111 -> result 0, err 1, latency 1.
REQ-032 SHALL verify: N=64, MUL accepted then reset pulsed 5 cycles later -> next cycle out_valid 0, result 0, in_ready 1 after release; following ADD 2+3 -> 5.
REQ-033 SHALL verify: N=64, LSL a=1 b=0x43 (shift 3) -> 8; LSR a=0x8000_0000_0000_0000 b=63 -> 1.
